// File: rtl/ring_osc_ctrl.sv
// Start/done frequency meter for the 5-stage ring oscillator: settle, count tap edges over a gate window, report.
// Optional RING_OSC_CTRL_CONTINUOUS_EN: back-to-back windows while iStart stays high.
module ring_osc_ctrl #(
  parameter int GATE_CYCLES   = 1000,
  parameter int SETTLE_CYCLES = 8,
  parameter int CNT_W         = 16
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iStart,
  input  logic             iRingTap,
  output logic             oRingEnable,
  output logic             oBusy,
  output logic             oDone,
  output logic [CNT_W-1:0] oCount,
  output logic             oOverflow
);

  localparam int MAXC_RAW = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int MAXC     = (MAXC_RAW > 2) ? MAXC_RAW : 2;
  localparam int TMR_W    = $clog2(MAXC);

  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GATE_LD   = TMR_W'(GATE_CYCLES - 1);
  localparam logic [TMR_W-1:0] DRAIN_LD  = TMR_W'(1);
  localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_GATE   = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [2:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_out_q, ovf_out_d;
  logic             edge_det;
`ifdef RING_OSC_CTRL_CONTINUOUS_EN
  logic             cont_q, cont_d;
`endif

  // sync_q[1:0] is the two-flop synchronizer, sync_q[2] the delayed copy for edge detection
  always_comb begin
    sync_d   = {sync_q[1:0], iRingTap};
    edge_det = sync_q[1] & ~sync_q[2];
  end

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    count_d   = count_q;
    ovf_out_d = ovf_out_q;
`ifdef RING_OSC_CTRL_CONTINUOUS_EN
    cont_d    = cont_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          state_d = S_SETTLE;
          tmr_d   = SETTLE_LD;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      S_SETTLE: begin
        if (tmr_q == '0) begin
          state_d = S_GATE;
          tmr_d   = GATE_LD;
        end else begin
          tmr_d = tmr_q - TMR_ONE;
        end
      end
      S_GATE: begin
        if (edge_det) begin
          if (cnt_q == CNT_MAX) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        if (tmr_q == '0) begin
          state_d = S_DRAIN;
          tmr_d   = DRAIN_LD;
`ifdef RING_OSC_CTRL_CONTINUOUS_EN
          // Decide at window close whether the ring keeps running through DRAIN/DONE
          cont_d  = iStart;
`endif
        end else begin
          tmr_d = tmr_q - TMR_ONE;
        end
      end
      S_DRAIN: begin
        if (tmr_q == '0) begin
          state_d   = S_DONE;
          count_d   = cnt_q;
          ovf_out_d = ovf_q;
        end else begin
          tmr_d = tmr_q - TMR_ONE;
        end
      end
      S_DONE: begin
`ifdef RING_OSC_CTRL_CONTINUOUS_EN
        if (iStart) begin
          state_d = S_GATE;
          tmr_d   = GATE_LD;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
          cont_d  = 1'b0;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q   <= S_IDLE;
      tmr_q     <= '0;
      sync_q    <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      count_q   <= '0;
      ovf_out_q <= 1'b0;
`ifdef RING_OSC_CTRL_CONTINUOUS_EN
      cont_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      count_q   <= count_d;
      ovf_out_q <= ovf_out_d;
`ifdef RING_OSC_CTRL_CONTINUOUS_EN
      cont_q    <= cont_d;
`endif
    end
  end

  // Outputs decode straight from registered state so reset drops the ring enable at once
  always_comb begin
`ifdef RING_OSC_CTRL_CONTINUOUS_EN
    oRingEnable = (state_q == S_SETTLE) || (state_q == S_GATE) ||
                  (cont_q && ((state_q == S_DRAIN) || (state_q == S_DONE)));
`else
    oRingEnable = (state_q == S_SETTLE) || (state_q == S_GATE);
`endif
    oBusy     = (state_q != S_IDLE);
    oDone     = (state_q == S_DONE);
    oCount    = count_q;
    oOverflow = ovf_out_q;
  end

endmodule

// File: tb/tb_ring_osc_ctrl.sv
// Directed bench for ring_osc_ctrl: a 16-bit and a 4-bit counter instance share stimulus and a tap model.
module tb_ring_osc_ctrl;

  logic        iClk = 1'b0;
  logic        iRst_n = 1'b0;
  logic        iStart = 1'b0;
  logic        tap = 1'b0;
  logic        en16, busy16, done16, ovf16;
  logic [15:0] cnt16;
  logic        en4, busy4, done4, ovf4;
  logic [3:0]  cnt4;

  int n_chk = 0;
  int n_pass = 0;
  int tap_half = 0;
  int tc = 0;

  always #5 iClk = ~iClk;

  ring_osc_ctrl #(.GATE_CYCLES(100), .SETTLE_CYCLES(8), .CNT_W(16)) u16 (
    .iClk(iClk), .iRst_n(iRst_n), .iStart(iStart), .iRingTap(tap),
    .oRingEnable(en16), .oBusy(busy16), .oDone(done16), .oCount(cnt16), .oOverflow(ovf16)
  );

  ring_osc_ctrl #(.GATE_CYCLES(100), .SETTLE_CYCLES(8), .CNT_W(4)) u4 (
    .iClk(iClk), .iRst_n(iRst_n), .iStart(iStart), .iRingTap(tap),
    .oRingEnable(en4), .oBusy(busy4), .oDone(done4), .oCount(cnt4), .oOverflow(ovf4)
  );

  // Ring model: held low while disabled, toggles every tap_half cycles once enabled (0 = stuck low)
  always @(negedge iClk) begin
    if (!en16) begin
      tap = 1'b0;
      tc  = 0;
    end else begin
      tc = tc + 1;
      if (tc == tap_half) begin
        tap = ~tap;
        tc  = 0;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  typedef struct {
    int half;
    bit poke;
    int c16;
    int o16;
    int c4;
    int o4;
  } vec_t;

  vec_t vecs[7];

  // Pulses iStart (edge k) and follows the run from cycle k+1 to k+130
  task automatic run_vec(input vec_t v, input string tag);
    int done_at;
    int dones;
    int busy_after;
    tap_half = v.half;
    @(negedge iClk);
    iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    chk({tag, " busy@k+1"}, int'(busy16), 1);
    chk({tag, " en@k+1"}, int'(en16), 1);
    done_at = -1;
    dones = 0;
    busy_after = -1;
    for (int c = 1; c <= 130; c++) begin
      if (c > 1) @(negedge iClk);
      iStart = v.poke && (c >= 3) && (c <= 105) && ((c % 7) == 0);
      if (done16) begin
        dones++;
        if (done_at < 0) done_at = c;
      end
      if (done_at > 0 && c == done_at + 1) busy_after = int'(busy16);
    end
    iStart = 1'b0;
    chk({tag, " done_cycle"}, done_at, 111);
    chk({tag, " done_pulses"}, dones, 1);
    chk({tag, " busy_after_done"}, busy_after, 0);
    chk({tag, " count16"}, int'(cnt16), v.c16);
    chk({tag, " ovf16"}, int'(ovf16), v.o16);
    chk({tag, " count4"}, int'(cnt4), v.c4);
    chk({tag, " ovf4"}, int'(ovf4), v.o4);
  endtask

  initial begin
    vecs[0] = '{half: 5,  poke: 1'b0, c16: 10, o16: 0, c4: 10, o4: 0};
    vecs[1] = '{half: 2,  poke: 1'b0, c16: 25, o16: 0, c4: 15, o4: 1};
    vecs[2] = '{half: 5,  poke: 1'b1, c16: 10, o16: 0, c4: 10, o4: 0};
    vecs[3] = '{half: 1,  poke: 1'b0, c16: 50, o16: 0, c4: 15, o4: 1};
    vecs[4] = '{half: 0,  poke: 1'b0, c16: 0,  o16: 0, c4: 0,  o4: 0};
    vecs[5] = '{half: 50, poke: 1'b0, c16: 1,  o16: 0, c4: 1,  o4: 0};
    vecs[6] = '{half: 2,  poke: 1'b1, c16: 25, o16: 0, c4: 15, o4: 1};

    // Reset values, then idle with iStart low
    repeat (3) @(negedge iClk);
    chk("rst en16", int'(en16), 0);
    chk("rst busy16", int'(busy16), 0);
    chk("rst done16", int'(done16), 0);
    chk("rst count16", int'(cnt16), 0);
    chk("rst ovf16", int'(ovf16), 0);
    chk("rst busy4", int'(busy4), 0);
    iRst_n = 1'b1;
    repeat (20) @(negedge iClk);
    chk("idle en16", int'(en16), 0);
    chk("idle busy16", int'(busy16), 0);
    chk("idle done16", int'(done16), 0);
    chk("idle count16", int'(cnt16), 0);

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset in GATE cycle 50 (cycle k+58) while outputs still hold the previous run
    tap_half = 5;
    @(negedge iClk);
    iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    repeat (57) @(negedge iClk);
    chk("midrst pre en", int'(en16), 1);
    iRst_n = 1'b0;
    #1;
    chk("midrst en16", int'(en16), 0);
    chk("midrst busy16", int'(busy16), 0);
    chk("midrst count16", int'(cnt16), 0);
    chk("midrst count4", int'(cnt4), 0);
    chk("midrst ovf4", int'(ovf4), 0);
    repeat (3) @(negedge iClk);
    chk("midrst held en4", int'(en4), 0);
    iRst_n = 1'b1;
    repeat (2) @(negedge iClk);
    run_vec(vecs[0], "postrst");

`ifdef RING_OSC_CTRL_CONTINUOUS_EN
    begin
      int first_done;
      int last_done;
      int dones;
      int en_fell;
      tap_half = 5;
      first_done = -1;
      last_done = -1;
      dones = 0;
      en_fell = 0;
      @(negedge iClk);
      iStart = 1'b1;
      for (int c = 1; c <= 420; c++) begin
        @(negedge iClk);
        if (!en16) en_fell = 1;
        if (done16) begin
          dones++;
          if (first_done < 0) first_done = c;
          last_done = c;
          chk($sformatf("cont count16 @%0d", c), int'(cnt16), 10);
        end
      end
      iStart = 1'b0;
      chk("cont first_done", first_done, 111);
      chk("cont span", last_done - first_done, 309);
      chk("cont dones", dones, 4);
      chk("cont en_fell", en_fell, 0);
      @(negedge iClk);
      chk("cont stop busy", int'(busy16), 0);
      chk("cont stop en", int'(en16), 0);
    end
`else
    // iStart held through DONE: IDLE for one cycle, then the next run starts
    begin
      int done_at;
      int busy_idle;
      int busy_next;
      tap_half = 5;
      done_at = -1;
      busy_idle = -1;
      busy_next = -1;
      @(negedge iClk);
      iStart = 1'b1;
      for (int c = 1; c <= 113; c++) begin
        @(negedge iClk);
        if (done16 && done_at < 0) done_at = c;
        if (c == 112) busy_idle = int'(busy16);
        if (c == 113) busy_next = int'(busy16);
      end
      iStart = 1'b0;
      chk("hold done_cycle", done_at, 111);
      chk("hold busy_idle", busy_idle, 0);
      chk("hold busy_restart", busy_next, 1);
      done_at = -1;
      for (int c = 1; c <= 130; c++) begin
        @(negedge iClk);
        if (done16 && done_at < 0) done_at = c;
      end
      chk("hold second done", done_at, 110);
      chk("hold second count16", int'(cnt16), 10);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
